// File: rtl/key_io_pkg.sv
// ============================================================================
//  Module      : key_io_pkg
//  Description : Register offsets and select type for the push-button block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_io_pkg;

    typedef logic [1:0] key_reg_sel_t;

    localparam key_reg_sel_t KEY_REG_LEVEL = 2'd0;
    localparam key_reg_sel_t KEY_REG_EDGE  = 2'd1;
    localparam key_reg_sel_t KEY_REG_MASK  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/key_input_ctrl_if.sv
// ============================================================================
//  Module      : key_input_ctrl_if
//  Description : CPU load/store bus between the I/O decode and the key block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface key_input_ctrl_if;
    import key_io_pkg::*;

    logic         cs;
    key_reg_sel_t reg_sel;
    logic         we;
    logic [31:0]  wdata;
    logic [31:0]  rdata;

    modport master (output cs, output reg_sel, output we, output wdata, input rdata);
    modport slave  (input cs, input reg_sel, input we, input wdata, output rdata);

endinterface

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
//  Module      : debounce_bit
//  Description : Two-flop synchronizer, polarity fix and counter debounce for
//                a single key; o_rise pulses on the cycle the level goes 0->1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_raw,
    output logic      o_level,
    output logic      o_rise
);

    localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           C_INVERT   = (ACTIVE_LOW != 0);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    logic          w_pressed;
    logic          w_accept;

    assign w_pressed = r_sync2 ^ C_INVERT;
    assign w_accept  = (w_pressed != r_stable) && (r_cnt == C_LAST);

    // Synchronizer resets to the released pin level so no false press appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= C_INVERT;
            r_sync2  <= C_INVERT;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
            if (w_pressed == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= w_pressed;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_accept & w_pressed;

endmodule

`default_nettype wire

// File: rtl/key_input_ctrl.sv
// ============================================================================
//  Module      : key_input_ctrl
//  Description : Debounced push-button peripheral with sticky press capture.
//                Optional mask register and interrupt under KEY_IRQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_input_ctrl
    import key_io_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [N_KEYS-1:0]  key_raw,
    key_input_ctrl_if.slave         bus,
    output logic      [N_KEYS-1:0]  key_level,
    output logic                    irq
);

    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_clr;
    logic [N_KEYS-1:0] w_mask;
    logic              w_edge_wr;
    logic              w_unused_wdata;
    logic [N_KEYS-1:0] r_edge;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk       (clk),
            .rst       (reset),
            .i_key_raw (key_raw[gi]),
            .o_level   (w_level[gi]),
            .o_rise    (w_rise[gi])
        );
    end

    assign key_level      = w_level;
    assign w_unused_wdata = ^bus.wdata;

    assign w_edge_wr = bus.cs & bus.we & (bus.reg_sel == KEY_REG_EDGE);
    assign w_clr     = w_edge_wr ? bus.wdata[N_KEYS-1:0] : '0;

    // A new press beats a same-cycle write-1-to-clear so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
        end
    end

`ifdef KEY_IRQ_EN
    logic [N_KEYS-1:0] r_mask;
    logic              r_irq;
    logic              w_mask_wr;

    assign w_mask_wr = bus.cs & bus.we & (bus.reg_sel == KEY_REG_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_mask_wr) begin
                r_mask <= bus.wdata[N_KEYS-1:0];
            end
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign irq    = r_irq;
`else
    assign w_mask = '0;
    assign irq    = 1'b0;
`endif

    // Reads are side-effect free; the CPU may sample rdata several times.
    always_comb begin
        bus.rdata = '0;
        if (bus.cs) begin
            case (bus.reg_sel)
                KEY_REG_LEVEL: bus.rdata = 32'(w_level);
                KEY_REG_EDGE:  bus.rdata = 32'(r_edge);
                KEY_REG_MASK:  bus.rdata = 32'(w_mask);
                default:       bus.rdata = '0;
            endcase
        end
    end

endmodule

`default_nettype wire
